inc_counter_seq_ctrl: RTL
=========================

// Module: inc_counter_seq_ctrl
// PURPOSE
//  Sequencer for an external loadable 8-bit-style up-counter (ports: data/load/enable, sync load>enable).
//  Runs the counter from a start value to an end value, repeating N periods or continuously.
//  Supports pause and abort. Gives per-period wrap and end-of-job done pulses to the system controller.
//  Sits between the control FSM (start/abort) and one counter instance.
// PARAMETERS
//  WIDTH  8  counter/value width in bits
//  REP_W  4  width of repeat count
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      job request; sampled only in IDLE
//  start_value  in   WIDTH  counter load value, captured on accepted start
//  end_value    in   WIDTH  terminal value, captured on accepted start
//  repeat_cnt   in   REP_W  number of periods; 0 = continuous until abort
//  pause        in   1      freezes counting in RUN (level)
//  abort        in   1      terminates job, returns to IDLE (level, highest priority)
//  busy         out  1      high in LOAD and RUN
//  wrap         out  1      1-cycle pulse: counter reached end_value (period complete)
//  done         out  1      1-cycle pulse: final period complete (not on abort)
//  cnt_data     out  WIDTH  to counter data; = captured start value
//  cnt_load     out  1      to counter load
//  cnt_enable   out  1      to counter enable
//  cnt_value    in   WIDTH  from counter out
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; start/end/rep registers=0; all outputs 0.
//  States: IDLE, LOAD, RUN, DONE. Outputs are decoded from state, registers and cnt_value.
//  IDLE: all outputs 0.
//   - start=1 & abort=0 -> capture start_value/end_value/repeat_cnt (rep_left); go to LOAD.
//  LOAD: cnt_load=1, busy=1; go to RUN. pause does not delay LOAD.
//  RUN: busy=1; hit = (cnt_value==end_reg).
//   - cnt_enable = !hit & !pause & !abort.
//   - hit -> wrap=1 (ignores pause).
//     - rep_left==1: go to DONE.
//     - rep_left==0 (continuous): go to LOAD.
//     - otherwise: rep_left-=1; go to LOAD.
//  DONE: done=1, busy=0; go to IDLE. A start in DONE is ignored.
//  start while busy: ignored, no queuing.
//  abort=1 in LOAD, RUN or DONE:
//   - cnt_load, cnt_enable, wrap and done are forced 0 that cycle.
//   - Next state is IDLE. Counter value is left as-is.
//  abort and start together in IDLE: stay in IDLE.
//  Arithmetic is modulo 2^WIDTH.
//   - end<start counts through all-ones -> 0 to end.
//   - start==end: 1 RUN cycle per period, zero increments.
//  Counter latency assumption: the counter is a registered, synchronous load/enable counter.
//  Timing, with D = (end-start) mod 2^WIDTH, no pause:
//   - start sampled at edge 0.
//   - cnt_value==start after edge 2.
//   - Each period = D+2 cycles (LOAD + D+1 RUN).
//   - done high in the cycle after edge (rep*(D+2)+1) for rep>=1.
//  Each pause cycle in RUN lengthens the period by exactly 1 cycle.
//  rep_left and captured values change only on an accepted start or a period complete.
//   - Input changes mid-job have no effect.
// TESTING
//  1 start=1, start=3, end=6, rep=1 -> cnt_load 1 cycle.
//    cnt_value 3,4,5,6; wrap at 6; done 1 cycle after edge 6; busy low after.
//  2 start=250, end=2, rep=2 -> counts 250..255,0,1,2 twice.
//    2 wrap pulses, 2 load pulses; done after edge 21.
//  3 rep=1, pause high 3 cycles while cnt_value=4 -> cnt_enable=0 during pause.
//    Value holds 4; done delayed by exactly 3 cycles.
//  4 rep=0, start=0, end=1 -> wrap every 3 cycles indefinitely.
//    abort mid-RUN -> IDLE next cycle; no done; cnt_enable=0 from the abort cycle.
//  5 start pulsed during RUN and DONE -> ignored.
//    start==end=9, rep=3 -> 3 wraps, 0 enables, done after edge 7.
//  6 reset_n low mid-RUN (asynchronous, off-edge) -> all outputs 0 immediately.
//    After release, IDLE; the next start runs normally.

Source files
------------

// File: rtl/inc_counter_seq_ctrl_if.sv
// Control and counter-side signals of the counter sequencer.
// slave = sequencer view, master = system controller / counter side view.
interface inc_counter_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] end_value;
    logic [REP_W-1:0] repeat_cnt;
    logic             pause;
    logic             abort;
    logic             busy;
    logic             wrap;
    logic             done;
    logic [WIDTH-1:0] cnt_data;
    logic             cnt_load;
    logic             cnt_enable;
    logic [WIDTH-1:0] cnt_value;

    modport slave (
        input  start, start_value, end_value, repeat_cnt, pause, abort, cnt_value,
        output busy, wrap, done, cnt_data, cnt_load, cnt_enable
    );

    modport master (
        output start, start_value, end_value, repeat_cnt, pause, abort, cnt_value,
        input  busy, wrap, done, cnt_data, cnt_load, cnt_enable
    );
endinterface

// File: rtl/inc_counter_seq_ctrl.sv
// Sequences an external load/enable up-counter from a start to an end value
// for N periods (or continuously), with pause, abort, wrap and done pulses.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// LOAD  | counter loaded with captured start value
// RUN   | counting up until cnt_value reaches end value
// DONE  | one-cycle done pulse after the final period
module inc_counter_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    inc_counter_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] end_reg;
    logic [REP_W-1:0] rep_left;

    logic accept;
    logic hit;
    logic busy_c, wrap_c, done_c, load_c, enable_c;

    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign hit    = (state == RUN) && (bus.cnt_value == end_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rep_left only moves on a period that completes without abort; 0 means run forever
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_reg <= '0;
            end_reg   <= '0;
            rep_left  <= '0;
        end else if (accept) begin
            start_reg <= bus.start_value;
            end_reg   <= bus.end_value;
            rep_left  <= bus.repeat_cnt;
        end else if (hit && !bus.abort && (rep_left > REP_W'(1))) begin
            rep_left <= rep_left - REP_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        wrap_c    = 1'b0;
        done_c    = 1'b0;
        load_c    = 1'b0;
        enable_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                busy_c    = 1'b1;
                load_c    = !bus.abort;
                state_nxt = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    wrap_c    = 1'b1;
                    state_nxt = (rep_left == REP_W'(1)) ? DONE : LOAD;
                end else begin
                    enable_c = !bus.pause;
                end
            end
            DONE: begin
                done_c    = !bus.abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy       = busy_c;
    assign bus.wrap       = wrap_c;
    assign bus.done       = done_c;
    assign bus.cnt_load   = load_c;
    assign bus.cnt_enable = enable_c;
    assign bus.cnt_data   = (state == IDLE) ? '0 : start_reg;
endmodule
